lives_tracker: RTL and testbench



---
 rtl/game_pkg.sv | 17 +
 rtl/hit_filter.sv | 34 +++
 rtl/lives_tracker.sv | 85 ++++++++
 tb/tb_lives_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the lives tracker and its display path.
package game_pkg;
  localparam int LIVES_W = 2;

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_e;

  typedef logic [1:0] win_t;
  localparam win_t WIN_NONE = 2'b00;
  localparam win_t WIN_P1   = 2'b01;
  localparam win_t WIN_P2   = 2'b10;
  localparam win_t WIN_DRAW = 2'b11;

  // The player who ran out loses, so {p1_out, p2_out} is exactly the winner code.
  function automatic win_t win_code(input logic p1_out, input logic p2_out);
    return {p1_out, p2_out};
  endfunction
endpackage

// File: rtl/hit_filter.sv
// Per-player hit qualifier: rising-edge detect plus invulnerability cooldown.
module hit_filter #(
  parameter int COOLDOWN = 8,
  parameter int CD_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hit_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic accept_o
);
  logic            hit_q;
  logic [CD_W-1:0] cd_q, cd_d;

  assign accept_o = enable_i & hit_i & ~hit_q & (cd_q == '0);

  always_comb begin
    cd_d = cd_q;
    if (clear_i)             cd_d = '0;
    else if (accept_o)       cd_d = CD_W'(COOLDOWN);
    else if (cd_q != '0)     cd_d = cd_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= 1'b0;
      cd_q  <= '0;
    end else begin
      hit_q <= hit_i;
      cd_q  <= cd_d;
    end
  end
endmodule

// File: rtl/lives_tracker.sv
// Lives counters, end-of-game FSM and winner decode for a two-player game.
module lives_tracker
  import game_pkg::*;
#(
  parameter int INIT_LIVES = 3,
  parameter int COOLDOWN   = 8,
  parameter int CD_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hit1,
  input  logic               hit2,
  input  logic               restart,
  output logic [LIVES_W-1:0] lives1,
  output logic [LIVES_W-1:0] lives2,
  output logic               hit_ack1,
  output logic               hit_ack2,
  output logic               game_over,
  output logic [1:0]         winner
);
  localparam int NUM_P = 2;
  localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);

  state_e                          state_q;
  logic [NUM_P-1:0][LIVES_W-1:0]   lives_q, lives_d;
  logic [NUM_P-1:0]                hit_v, en_v, acc_v, ack_q;
  logic                            game_over_q;
  win_t                            winner_q;

  assign hit_v = {hit2, hit1};

  always_comb begin
    for (int i = 0; i < NUM_P; i++) begin
      en_v[i]    = (state_q == PLAY) & (lives_q[i] != '0) & ~restart;
      lives_d[i] = lives_q[i] - LIVES_W'(acc_v[i]);
    end
  end

  for (genvar g = 0; g < NUM_P; g++) begin : g_hf
    hit_filter #(.COOLDOWN(COOLDOWN), .CD_W(CD_W)) u_hf (
      .clk     (clk),
      .rst     (rst),
      .hit_i   (hit_v[g]),
      .enable_i(en_v[g]),
      .clear_i (restart),
      .accept_o(acc_v[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLAY;
      lives_q     <= {NUM_P{INIT_L}};
      ack_q       <= '0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else if (restart) begin
      state_q     <= PLAY;
      lives_q     <= {NUM_P{INIT_L}};
      ack_q       <= '0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      // In OVER the enables are low, so acc_v is zero and lives stay frozen.
      ack_q   <= acc_v;
      lives_q <= lives_d;
      case (state_q)
        PLAY: if (lives_d[0] == '0 || lives_d[1] == '0) begin
          state_q     <= OVER;
          game_over_q <= 1'b1;
          winner_q    <= win_code(lives_d[0] == '0, lives_d[1] == '0);
        end
        OVER: ;
        default: state_q <= PLAY;
      endcase
    end
  end

  assign lives1    = lives_q[0];
  assign lives2    = lives_q[1];
  assign hit_ack1  = ack_q[0];
  assign hit_ack2  = ack_q[1];
  assign game_over = game_over_q;
  assign winner    = winner_q;
endmodule

// File: tb/tb_lives_tracker.sv
// Scoreboard bench for lives_tracker: a cycle model pushes expected outputs per tick.
module tb_lives_tracker;
  localparam int COOL = 8;

  logic       clk = 1'b0;
  logic       rst, hit1, hit2, restart;
  logic [1:0] lives1, lives2, winner;
  logic       hit_ack1, hit_ack2, game_over;

  lives_tracker #(.INIT_LIVES(3), .COOLDOWN(COOL), .CD_W(4)) dut (
    .clk(clk), .rst(rst), .hit1(hit1), .hit2(hit2), .restart(restart),
    .lives1(lives1), .lives2(lives2), .hit_ack1(hit_ack1), .hit_ack2(hit_ack2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [10:0] sb[$];
  logic [2:0]  stim[$];   // {restart, hit2, hit1}

  // behavioural model state
  logic [1:0] m_l1, m_l2, m_win;
  logic       m_a1, m_a2, m_go, m_h1q, m_h2q;
  int         m_cd1, m_cd2;

  function automatic logic [10:0] outs();
    return {lives1, lives2, hit_ack1, hit_ack2, game_over, winner};
  endfunction

  task automatic model_reset();
    m_l1 = 2'd3; m_l2 = 2'd3; m_win = 2'b00; m_go = 1'b0;
    m_a1 = 1'b0; m_a2 = 1'b0; m_h1q = 1'b0; m_h2q = 1'b0;
    m_cd1 = 0; m_cd2 = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic h1, input logic h2, input logic rs);
    logic a1, a2;
    if (rs) begin
      m_l1 = 2'd3; m_l2 = 2'd3; m_win = 2'b00; m_go = 1'b0;
      m_a1 = 1'b0; m_a2 = 1'b0; m_cd1 = 0; m_cd2 = 0;
    end else begin
      a1 = !m_go && h1 && !m_h1q && m_cd1 == 0 && m_l1 != 0;
      a2 = !m_go && h2 && !m_h2q && m_cd2 == 0 && m_l2 != 0;
      if (a1) m_cd1 = COOL; else if (m_cd1 > 0) m_cd1--;
      if (a2) m_cd2 = COOL; else if (m_cd2 > 0) m_cd2--;
      if (a1) m_l1 = m_l1 - 2'd1;
      if (a2) m_l2 = m_l2 - 2'd1;
      m_a1 = a1; m_a2 = a2;
      if (!m_go && (m_l1 == 0 || m_l2 == 0)) begin
        m_go  = 1'b1;
        m_win = (m_l1 == 0 && m_l2 == 0) ? 2'b11 : (m_l1 == 0) ? 2'b10 : 2'b01;
      end
    end
    m_h1q = h1; m_h2q = h2;
  endtask

  // Drive one cycle of stimulus and queue the model's view of the result.
  task automatic tick(input logic h1, input logic h2, input logic rs);
    hit1 = h1; hit2 = h2; restart = rs;
    model_step(h1, h2, rs);
    sb.push_back({m_l1, m_l2, m_a1, m_a2, m_go, m_win});
    @(posedge clk); #1;
  endtask

  task automatic add(input logic [2:0] v, input int n);
    repeat (n) stim.push_back(v);
  endtask

  task automatic test_reset();
    rst = 1'b1; hit1 = 1'b0; hit2 = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 11'b11_11_0_0_0_00) begin
      failures++; $display("FAIL reset got=%h exp=%h", outs(), 11'b11_11_0_0_0_00);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_held();
    logic [10:0] e; logic [2:0] v; int acks = 0; int n = 0;
    add(3'b000, 2); add(3'b001, 20); add(3'b000, 10);
    while (stim.size() > 0) begin
      v = stim.pop_front(); tick(v[0], v[1], v[2]);
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin failures++; $display("FAIL held cyc=%0d got=%h exp=%h", n, outs(), e); end
      if (hit_ack1) acks++;
      n++;
    end
    checks++;
    if (lives1 !== 2'd2 || acks != 1) begin
      failures++; $display("FAIL held_final lives1=%0d acks=%0d exp lives1=2 acks=1", lives1, acks);
    end
  endtask

  task automatic test_cooldown();
    logic [10:0] e; logic [2:0] v; logic [1:0] l_mid = 2'd0; int n = 0;
    add(3'b100, 1); add(3'b000, 1);
    add(3'b001, 1); add(3'b000, 7);          // accept at k, low k+1..k+7
    add(3'b001, 2);                          // rise at k+8 rejected, held at k+9
    add(3'b000, 1); add(3'b001, 1);          // fresh rise at k+11 accepted
    add(3'b000, 10);
    add(3'b010, 1); add(3'b000, 8);          // player 2 accept at j
    add(3'b010, 1); add(3'b000, 10);         // rise at j+9 accepted
    while (stim.size() > 0) begin
      v = stim.pop_front(); tick(v[0], v[1], v[2]);
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin failures++; $display("FAIL cooldown cyc=%0d got=%h exp=%h", n, outs(), e); end
      if (n == 11) l_mid = lives1;
      n++;
    end
    checks++;
    if (l_mid !== 2'd2) begin failures++; $display("FAIL cd_reject lives1=%0d exp=2", l_mid); end
    checks++;
    if (lives1 !== 2'd1 || lives2 !== 2'd1) begin
      failures++; $display("FAIL cd_final lives1=%0d lives2=%0d exp 1/1", lives1, lives2);
    end
  endtask

  task automatic test_async_reset();
    hit1 = 1'b0; hit2 = 1'b0; restart = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 11'b11_11_0_0_0_00) begin
      failures++; $display("FAIL async_rst got=%h exp=%h", outs(), 11'b11_11_0_0_0_00);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_win();
    logic [10:0] e; logic [2:0] v; int n = 0; int late_ack = 0;
    logic [10:0] at_end = '0;
    add(3'b000, 2);
    repeat (3) begin add(3'b010, 1); add(3'b000, 19); end
    add(3'b001, 1); add(3'b000, 3);
    while (stim.size() > 0) begin
      v = stim.pop_front(); tick(v[0], v[1], v[2]);
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin failures++; $display("FAIL win cyc=%0d got=%h exp=%h", n, outs(), e); end
      if (n == 42) at_end = outs();
      if (n > 42 && hit_ack1) late_ack++;
      n++;
    end
    checks++;
    if (at_end !== 11'b11_00_0_1_1_01) begin
      failures++; $display("FAIL win_edge got=%h exp=%h", at_end, 11'b11_00_0_1_1_01);
    end
    checks++;
    if (lives1 !== 2'd3 || late_ack != 0 || winner !== 2'b01) begin
      failures++; $display("FAIL win_frozen lives1=%0d acks=%0d winner=%b exp 3/0/01", lives1, late_ack, winner);
    end
  endtask

  task automatic test_draw();
    logic [10:0] e; logic [2:0] v; int n = 0; int a1 = 0; int a2 = 0;
    add(3'b100, 1); add(3'b000, 1);
    repeat (3) begin add(3'b011, 1); add(3'b000, 19); end
    while (stim.size() > 0) begin
      v = stim.pop_front(); tick(v[0], v[1], v[2]);
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin failures++; $display("FAIL draw cyc=%0d got=%h exp=%h", n, outs(), e); end
      if (hit_ack1) a1++;
      if (hit_ack2) a2++;
      n++;
    end
    checks++;
    if (outs() !== 11'b00_00_0_0_1_11 || a1 != 3 || a2 != 3) begin
      failures++; $display("FAIL draw_final got=%h acks=%0d/%0d exp=%h acks 3/3", outs(), a1, a2, 11'b00_00_0_0_1_11);
    end
  endtask

  task automatic test_restart();
    logic [10:0] e; logic [2:0] v; int n = 0; logic [10:0] at_rs = '0;
    add(3'b100, 1); add(3'b000, 1);
    add(3'b001, 1); add(3'b000, 10);   // lives1 = 2, cooldown expired
    add(3'b001, 1); add(3'b000, 2);    // second hit starts a cooldown
    add(3'b101, 1);                    // restart with simultaneous rise
    add(3'b000, 1); add(3'b001, 1); add(3'b000, 2);
    while (stim.size() > 0) begin
      v = stim.pop_front(); tick(v[0], v[1], v[2]);
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin failures++; $display("FAIL restart cyc=%0d got=%h exp=%h", n, outs(), e); end
      if (n == 16) at_rs = outs();
      n++;
    end
    checks++;
    if (at_rs !== 11'b11_11_0_0_0_00) begin
      failures++; $display("FAIL restart_prio got=%h exp=%h", at_rs, 11'b11_11_0_0_0_00);
    end
    checks++;
    if (lives1 !== 2'd2) begin failures++; $display("FAIL restart_next lives1=%0d exp=2", lives1); end
  endtask

  initial begin
    test_reset();
    test_held();
    test_cooldown();
    test_async_reset();
    test_win();
    test_draw();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
